// File: rtl/ddr3_arb_pkg.sv
// ddr3_arb_pkg: shared constants and types for the DDR3 request arbiter.
// Source encodings, starvation counter width and the one-hot grant bundle.
package ddr3_arb_pkg;

    localparam int WAIT_BITS = 8;

    localparam logic [1:0] SRC_WRITE  = 2'b00;
    localparam logic [1:0] SRC_READ   = 2'b01;
    localparam logic [1:0] SRC_BYPASS = 2'b10;

    typedef struct packed {
        logic by;
        logic rd;
        logic wr;
    } gnt_t;

    function automatic logic [1:0] gnt_src(gnt_t g);
        logic [1:0] s;
        s = SRC_WRITE;
        unique case (1'b1)
            g.by:    s = SRC_BYPASS;
            g.rd:    s = SRC_READ;
            default: s = SRC_WRITE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ddr3_req_arbiter_if.sv
// ddr3_req_arbiter_if: request ports of the three sources plus the
// command port towards the DDR3 controller FSM.
interface ddr3_req_arbiter_if #(
    parameter int ADDRS = 23,
    parameter int REQID = 4
) ();
    logic             wr_valid_i;
    logic             wr_ready_o;
    logic [ADDRS-1:0] wr_addr_i;
    logic [REQID-1:0] wr_id_i;
    logic             rd_valid_i;
    logic             rd_ready_o;
    logic [ADDRS-1:0] rd_addr_i;
    logic [REQID-1:0] rd_id_i;
    logic             by_valid_i;
    logic             by_ready_o;
    logic [ADDRS-1:0] by_addr_i;
    logic [REQID-1:0] by_id_i;
    logic             mem_valid_o;
    logic             mem_ready_i;
    logic             mem_store_o;
    logic [1:0]       mem_src_o;
    logic [ADDRS-1:0] mem_addr_o;
    logic [REQID-1:0] mem_id_o;

    // Arbiter side
    modport slave (
        input  wr_valid_i, wr_addr_i, wr_id_i,
        input  rd_valid_i, rd_addr_i, rd_id_i,
        input  by_valid_i, by_addr_i, by_id_i,
        input  mem_ready_i,
        output wr_ready_o, rd_ready_o, by_ready_o,
        output mem_valid_o, mem_store_o, mem_src_o,
        output mem_addr_o, mem_id_o
    );

    // Requester / controller side
    modport master (
        output wr_valid_i, wr_addr_i, wr_id_i,
        output rd_valid_i, rd_addr_i, rd_id_i,
        output by_valid_i, by_addr_i, by_id_i,
        output mem_ready_i,
        input  wr_ready_o, rd_ready_o, by_ready_o,
        input  mem_valid_o, mem_store_o, mem_src_o,
        input  mem_addr_o, mem_id_o
    );

endinterface

// File: rtl/ddr3_arb_select.sv
// ddr3_arb_select: combinational priority and RAW-hazard selection.
// Starved write > bypass > read > write; hazards defer to the write.
module ddr3_arb_select
    import ddr3_arb_pkg::*;
#(
    parameter int ADDRS = 23
) (
    input  logic             i_wr_valid,
    input  logic [ADDRS-1:0] i_wr_addr,
    input  logic             i_rd_valid,
    input  logic [ADDRS-1:0] i_rd_addr,
    input  logic             i_by_valid,
    input  logic [ADDRS-1:0] i_by_addr,
    input  logic             i_starve,
    output gnt_t             o_gnt
);

    logic w_rd_haz;
    logic w_by_haz;

    assign w_rd_haz = i_wr_valid && (i_rd_addr == i_wr_addr);
    assign w_by_haz = i_wr_valid && (i_by_addr == i_wr_addr);

    // Pick exactly one source; a read that hits the pending write waits
    always_comb begin
        o_gnt = '0;
        if (i_wr_valid && i_starve) begin
            o_gnt.wr = 1'b1;
        end else if (i_by_valid && !w_by_haz) begin
            o_gnt.by = 1'b1;
        end else if (i_rd_valid && !w_rd_haz) begin
            o_gnt.rd = 1'b1;
        end else if (i_wr_valid) begin
            o_gnt.wr = 1'b1;
        end
    end

endmodule

// File: rtl/ddr3_req_arbiter.sv
// ddr3_req_arbiter: schedules write/read/bypass bursts into one command
// port through a single registered stage (one cycle of latency).
module ddr3_req_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int ADDRS         = 23,
    parameter int REQID         = 4,
    parameter int WR_MAX_WAIT   = 8,
    parameter int BYPASS_ENABLE = 0
) (
    input  logic             clock,
    input  logic             reset,
    ddr3_req_arbiter_if.slave bus
);

    localparam logic [WAIT_BITS-1:0] MAX_W = WAIT_BITS'(WR_MAX_WAIT);

    logic [WAIT_BITS-1:0] r_wait_cnt;
    logic                 r_valid;
    logic                 r_store;
    logic [1:0]           r_src;
    logic [ADDRS-1:0]     r_addr;
    logic [REQID-1:0]     r_id;

    logic             w_by_valid;
    logic             w_starve;
    logic             w_free;
    logic             w_go;
    logic             w_any;
    gnt_t             w_gnt;
    logic [ADDRS-1:0] w_addr;
    logic [REQID-1:0] w_id;

    assign w_by_valid = (BYPASS_ENABLE != 0) && bus.by_valid_i;
    assign w_starve   = (r_wait_cnt == MAX_W);
    assign w_free     = !r_valid || bus.mem_ready_i;
    assign w_go       = w_free && !reset;
    assign w_any      = w_go && (w_gnt != '0);

    ddr3_arb_select #(
        .ADDRS (ADDRS)
    ) u_sel (
        .i_wr_valid (bus.wr_valid_i),
        .i_wr_addr  (bus.wr_addr_i),
        .i_rd_valid (bus.rd_valid_i),
        .i_rd_addr  (bus.rd_addr_i),
        .i_by_valid (w_by_valid),
        .i_by_addr  (bus.by_addr_i),
        .i_starve   (w_starve),
        .o_gnt      (w_gnt)
    );

    assign bus.wr_ready_o = w_go && w_gnt.wr;
    assign bus.rd_ready_o = w_go && w_gnt.rd;
    assign bus.by_ready_o = w_go && w_gnt.by;

    assign bus.mem_valid_o = r_valid;
    assign bus.mem_store_o = r_store;
    assign bus.mem_src_o   = r_src;
    assign bus.mem_addr_o  = r_addr;
    assign bus.mem_id_o    = r_id;

    // Route the winning source's address and ID to the output stage
    always_comb begin
        w_addr = bus.wr_addr_i;
        w_id   = bus.wr_id_i;
        unique case (1'b1)
            w_gnt.by: begin
                w_addr = bus.by_addr_i;
                w_id   = bus.by_id_i;
            end
            w_gnt.rd: begin
                w_addr = bus.rd_addr_i;
                w_id   = bus.rd_id_i;
            end
            default: begin
                w_addr = bus.wr_addr_i;
                w_id   = bus.wr_id_i;
            end
        endcase
    end

    // Output stage: load on grant, drop after handshake, hold on stall
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_store <= 1'b0;
            r_src   <= SRC_WRITE;
            r_addr  <= '0;
            r_id    <= '0;
        end else if (w_free) begin
            r_valid <= w_any;
            if (w_any) begin
                r_store <= w_gnt.wr;
                r_src   <= gnt_src(w_gnt);
                r_addr  <= w_addr;
                r_id    <= w_id;
            end
        end
    end

    // Count lost arbitrations of a pending write, saturating at the limit
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (!bus.wr_valid_i || bus.wr_ready_o) begin
            r_wait_cnt <= '0;
        end else if (w_free && !w_starve) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr3_req_arbiter.sv
// tb_ddr3_req_arbiter: directed stimulus on two arbiters (bypass off/on),
// a per-cycle reference model and hand-computed literal expectations.
module tb_ddr3_req_arbiter;

    localparam int AW   = 23;
    localparam int IW   = 4;
    localparam int MAXW = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic          wv[2], rv[2], bv[2], mr[2];
    logic [AW-1:0] wa[2], ra[2], ba[2];
    logic [IW-1:0] wi[2], ri[2], bi[2];
    logic          wrdy[2], rrdy[2], brdy[2], mv[2], ms[2];
    logic [1:0]    msrc[2];
    logic [AW-1:0] ma[2];
    logic [IW-1:0] mid[2];
    logic [7:0]    wc[2];

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_inst
            ddr3_req_arbiter_if #(.ADDRS(AW), .REQID(IW)) bus ();
            assign bus.wr_valid_i  = wv[g];
            assign bus.wr_addr_i   = wa[g];
            assign bus.wr_id_i     = wi[g];
            assign bus.rd_valid_i  = rv[g];
            assign bus.rd_addr_i   = ra[g];
            assign bus.rd_id_i     = ri[g];
            assign bus.by_valid_i  = bv[g];
            assign bus.by_addr_i   = ba[g];
            assign bus.by_id_i     = bi[g];
            assign bus.mem_ready_i = mr[g];
            assign wrdy[g] = bus.wr_ready_o;
            assign rrdy[g] = bus.rd_ready_o;
            assign brdy[g] = bus.by_ready_o;
            assign mv[g]   = bus.mem_valid_o;
            assign ms[g]   = bus.mem_store_o;
            assign msrc[g] = bus.mem_src_o;
            assign ma[g]   = bus.mem_addr_o;
            assign mid[g]  = bus.mem_id_o;
            ddr3_req_arbiter #(
                .ADDRS(AW), .REQID(IW),
                .WR_MAX_WAIT(MAXW), .BYPASS_ENABLE(g)
            ) dut (
                .clock (clock),
                .reset (reset),
                .bus   (bus.slave)
            );
            assign wc[g] = dut.r_wait_cnt;
        end
    endgenerate

    int errs   = 0;
    int checks = 0;
    bit armed  = 0;

    task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s inst%0d: got %0h want %0h", nm, i, act, exp);
        end
    endtask

    // Reference model: expected command register and write wait count
    logic          e_v[2], e_s[2], e_z[2];
    logic [1:0]    e_src[2];
    logic [AW-1:0] e_a[2];
    logic [IW-1:0] e_id[2];
    int            e_wc[2];

    // 0 none, 1 write, 2 read, 3 bypass
    function automatic int pick(int i, bit free);
        bit wr_hit_rd, wr_hit_by;
        wr_hit_rd = wv[i] && (ra[i] == wa[i]);
        wr_hit_by = wv[i] && (ba[i] == wa[i]);
        if (!free || reset) return 0;
        if (wv[i] && e_wc[i] == MAXW) return 1;
        if (i == 1 && bv[i] && !wr_hit_by) return 3;
        if (rv[i] && !wr_hit_rd) return 2;
        if (wv[i]) return 1;
        return 0;
    endfunction

    always @(negedge clock) begin
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                bit free;
                int p;
                free = !e_v[i] || mr[i];
                p = pick(i, free);
                chk("wr_ready", i, wrdy[i], p == 1);
                chk("rd_ready", i, rrdy[i], p == 2);
                chk("by_ready", i, brdy[i], p == 3);
                chk("mem_valid", i, mv[i], e_v[i]);
                chk("wait_cnt", i, wc[i], e_wc[i]);
                if (e_v[i] || e_z[i]) begin
                    chk("mem_store", i, ms[i], e_s[i]);
                    chk("mem_src", i, msrc[i], e_src[i]);
                    chk("mem_addr", i, ma[i], e_a[i]);
                    chk("mem_id", i, mid[i], e_id[i]);
                end
                if (reset) begin
                    e_v[i] = 0; e_s[i] = 0; e_src[i] = 0;
                    e_a[i] = 0; e_id[i] = 0; e_z[i] = 1; e_wc[i] = 0;
                end else begin
                    if (!wv[i] || p == 1) e_wc[i] = 0;
                    else if (free && e_wc[i] < MAXW) e_wc[i]++;
                    if (free) begin
                        e_v[i] = (p != 0);
                        if (p != 0) begin
                            e_z[i]   = 0;
                            e_s[i]   = (p == 1);
                            e_src[i] = (p == 1) ? 2'b00 : (p == 2) ? 2'b01 : 2'b10;
                            e_a[i]   = (p == 1) ? wa[i] : (p == 2) ? ra[i] : ba[i];
                            e_id[i]  = (p == 1) ? wi[i] : (p == 2) ? ri[i] : bi[i];
                        end
                    end
                end
            end
        end
    end

    // Grants seen in the last cycle; granted sources drop their valid
    logic gw[2], gr[2], gb[2];

    task automatic tick();
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            gw[i] = wrdy[i]; gr[i] = rrdy[i]; gb[i] = brdy[i];
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (gw[i]) wv[i] = 0;
            if (gr[i]) rv[i] = 0;
            if (gb[i]) bv[i] = 0;
        end
    endtask

    task automatic drain(int i);
        for (int n = 0; n < 30; n++) begin
            if (!wv[i] && !rv[i] && !bv[i] && !mv[i]) break;
            tick();
        end
        chk("drain_idle", i, {wv[i], rv[i], bv[i], mv[i]}, 0);
    endtask

    task automatic req_w(int i, int a, int id);
        wv[i] = 1; wa[i] = AW'(a); wi[i] = IW'(id);
    endtask

    task automatic req_r(int i, int a, int id);
        rv[i] = 1; ra[i] = AW'(a); ri[i] = IW'(id);
    endtask

    task automatic req_b(int i, int a, int id);
        bv[i] = 1; ba[i] = AW'(a); bi[i] = IW'(id);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            wv[i] = 0; rv[i] = 0; bv[i] = 0; mr[i] = 0;
            wa[i] = 0; ra[i] = 0; ba[i] = 0;
            wi[i] = 0; ri[i] = 0; bi[i] = 0;
            gw[i] = 0; gr[i] = 0; gb[i] = 0;
            e_v[i] = 0; e_s[i] = 0; e_z[i] = 1; e_src[i] = 0;
            e_a[i] = 0; e_id[i] = 0; e_wc[i] = 0;
        end
        repeat (2) @(posedge clock);
        #1;
        armed = 1;
        tick();
        chk("rst_valid", 0, mv[0], 0);
        chk("rst_addr", 0, ma[0], 0);
        chk("rst_wait", 0, wc[0], 0);
        reset = 0;
        mr[0] = 1;
        mr[1] = 1;

        // Single read, one cycle of latency
        req_r(0, 'h10, 1);
        tick();
        chk("t1_grant", 0, gr[0], 1);
        chk("t1_valid", 0, mv[0], 1);
        chk("t1_store", 0, ms[0], 0);
        chk("t1_src", 0, msrc[0], 1);
        chk("t1_addr", 0, ma[0], 'h10);
        chk("t1_id", 0, mid[0], 1);
        tick();
        chk("t1_idle", 0, mv[0], 0);

        // Read beats write on distinct addresses
        req_w(0, 'h20, 2);
        req_r(0, 'h40, 3);
        tick();
        chk("t2_first", 0, {msrc[0], ma[0]}, {2'b01, 23'h40});
        tick();
        chk("t2_second", 0, {ms[0], msrc[0], ma[0]}, {1'b1, 2'b00, 23'h20});
        drain(0);

        // Starvation: the write wins on the 9th arbitration
        req_w(0, 'h80, 5);
        for (n = 1; n <= 12; n++) begin
            if (!rv[0]) req_r(0, 'h200 + n, n);
            tick();
            if (gw[0]) break;
        end
        chk("t3_starve_cycle", 0, n, 9);
        chk("t3_wait_clear", 0, wc[0], 0);
        chk("t3_addr", 0, {ms[0], ma[0]}, {1'b1, 23'h80});
        drain(0);

        // RAW hazard: write first, then the matching read
        req_w(0, 'h100, 6);
        req_r(0, 'h100, 7);
        tick();
        chk("t4_write", 0, {ms[0], ma[0], mid[0]}, {1'b1, 23'h100, 4'd6});
        tick();
        chk("t4_read", 0, {ms[0], ma[0], mid[0]}, {1'b0, 23'h100, 4'd7});
        drain(0);

        // Controller stall holds the command and blocks grants
        req_r(0, 'h300, 8);
        tick();
        mr[0] = 0;
        req_r(0, 'h304, 9);
        req_w(0, 'h308, 10);
        repeat (5) tick();
        chk("t5_hold", 0, {mv[0], ma[0], mid[0]}, {1'b1, 23'h300, 4'd8});
        chk("t5_no_grant", 0, {gw[0], gr[0]}, 0);
        mr[0] = 1;
        tick();
        chk("t5_regrant", 0, gr[0], 1);
        chk("t5_addr", 0, ma[0], 'h304);
        drain(0);

        // Reset during a stalled command
        req_w(0, 'h500, 11);
        req_r(0, 'h504, 12);
        tick();
        mr[0] = 0;
        tick();
        chk("t6_wait", 0, wc[0], 1);
        reset = 1;
        tick();
        reset = 0;
        wv[0] = 0;
        rv[0] = 0;
        chk("t6_clear", 0, {mv[0], ms[0], msrc[0], ma[0], mid[0]}, 0);
        chk("t6_wait_clear", 0, wc[0], 0);
        mr[0] = 1;

        // Bypass disabled: read unaffected
        req_b(0, 'h600, 2);
        req_r(0, 'h610, 3);
        tick();
        chk("t7_by_off", 0, {gb[0], gr[0], msrc[0]}, {1'b0, 1'b1, 2'b01});
        tick();
        chk("t7_by_never", 0, gb[0], 0);
        bv[0] = 0;
        drain(0);

        // Bypass enabled: bypass > read > write
        req_b(1, 'h700, 1);
        req_r(1, 'h710, 2);
        req_w(1, 'h720, 3);
        tick();
        chk("t8_by", 1, {msrc[1], ma[1]}, {2'b10, 23'h700});
        tick();
        chk("t8_rd", 1, {msrc[1], ma[1]}, {2'b01, 23'h710});
        tick();
        chk("t8_wr", 1, {ms[1], msrc[1], ma[1]}, {1'b1, 2'b00, 23'h720});
        drain(1);

        // Bypass hazard against pending write
        req_w(1, 'h800, 4);
        req_b(1, 'h800, 5);
        req_r(1, 'h810, 6);
        tick();
        chk("t9_rd", 1, {msrc[1], ma[1]}, {2'b01, 23'h810});
        tick();
        chk("t9_wr", 1, {msrc[1], ma[1]}, {2'b00, 23'h800});
        tick();
        chk("t9_by", 1, {msrc[1], ma[1], mid[1]}, {2'b10, 23'h800, 4'd5});
        drain(1);

        armed = 0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ddr3_req_arbiter.md
Name: ddr3_req_arbiter

Overview:
- Schedules burst requests from three sources into the single command port of the DDR3 controller FSM.
- The three sources are the AXI write-address path, the AXI read-address path and the optional fast-read bypass path.
- Applies fixed priority (bypass > read > write) with a bounded write-starvation limit.
- Enforces read-after-write ordering on matching burst addresses.
- Provides a one-deep registered output stage, so the arbiter adds exactly one cycle of latency.

Parameters:
- ADDRS, 23, width of the burst-aligned address (AXI byte address bits [26:4]).
- REQID, 4, request-ID width.
- WR_MAX_WAIT, 8, number of consecutive lost arbitrations before a pending write is forced through; must be ≥1 and ≤255.
- BYPASS_ENABLE, 0, 1 enables the bypass port; 0 ties by_ready_o low and ignores by_valid_i.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_valid_i  in  1  write request valid
- wr_ready_o  out  1  write request accepted (grant) this cycle
- wr_addr_i  in  ADDRS  write burst address
- wr_id_i  in  REQID  write ID
- rd_valid_i  in  1  read request valid
- rd_ready_o  out  1  read grant
- rd_addr_i  in  ADDRS  read burst address
- rd_id_i  in  REQID  read ID
- by_valid_i  in  1  bypass read valid
- by_ready_o  out  1  bypass grant
- by_addr_i  in  ADDRS  bypass burst address
- by_id_i  in  REQID  bypass ID
- mem_valid_o  out  1  command valid to controller FSM
- mem_ready_i  in  1  controller accepts command
- mem_store_o  out  1  1 = write burst, 0 = read burst
- mem_src_o  out  2  source of command: 00 write, 01 read, 10 bypass
- mem_addr_o  out  ADDRS  burst address
- mem_id_o  out  REQID  request ID

Behaviour:
- Reset values:
  - mem_valid_o=0, mem_store_o=0, mem_src_o=00, mem_addr_o=0, mem_id_o=0.
  - Wait counter = 0.
  - All *_ready_o = 0 while reset is high.
  - A reset asserted mid-operation drops any held command without handshake.
- Output stage:
  - `free = !mem_valid_o || mem_ready_i`.
  - Grants are issued only when `free`.
  - The granted request is loaded into the mem_* registers on the same edge, so mem_valid_o rises on the next cycle (latency 1).
  - When `free` and no grant, mem_valid_o → 0 after the handshake.
  - Supports back-to-back grants at full rate while mem_ready_i is held high.
- Grants:
  - *_ready_o is combinational: `free && selected source`.
  - At most one ready is high per cycle.
  - Ready never asserts without the corresponding valid.
- Selection, in order:
  1. If `wr_valid_i && wait_cnt == WR_MAX_WAIT`, select write (starvation override; it beats the bypass port too).
  2. Otherwise, if `by_valid_i` (and BYPASS_ENABLE), select bypass; a bypass is suppressed if `by_addr_i == wr_addr_i && wr_valid_i`.
  3. Otherwise, if `rd_valid_i`, select read unless `wr_valid_i && rd_addr_i == wr_addr_i`.
  4. Otherwise, if `wr_valid_i`, select write.
- RAW hazard handling:
  - A read/bypass whose address matches the pending write is held, and the write is selected instead in that cycle, provided no non-hazard read source of higher priority wins.
  - Consequence: the write always issues before the matching read.
- Starvation counter (wait_cnt, 8 bits):
  - Increments when `free && wr_valid_i` and the write is not granted.
  - Clears on a write grant or when wr_valid_i is low.
  - Saturates at WR_MAX_WAIT.
- Valid/data stability:
  - Sources must hold valid/addr/id until granted.
  - The arbiter holds mem_* stable while `mem_valid_o && !mem_ready_i`.
- Simultaneous events: mem_ready_i handshake and new grant in the same cycle are permitted; the registers update with the new command.

Decomposition:
- Shared package ddr3_arb_pkg holds:
  - SRC_WRITE=2'b00, SRC_READ=2'b01, SRC_BYPASS=2'b10.
  - WAIT_BITS=8.
- One sub-module, ddr3_arb_select, contains the purely combinational priority/hazard select. It takes the valids, addresses and `wait_cnt==WR_MAX_WAIT`, and returns a one-hot grant.
- The top level holds the counter and the output register.

Test Plan:
- After reset release, rd_valid_i=1 with rd_addr_i=0x000010 and id=1, mem_ready_i=1 → rd_ready_o high 1 cycle. Next cycle: mem_valid_o=1, mem_store_o=0, mem_src_o=01, mem_addr_o=0x000010, mem_id_o=1.
- wr_valid_i and rd_valid_i both high, different addresses (0x20/0x40) → read granted first, write granted the following cycle. The output sequence is read then write, each held until mem_ready_i.
- Reads continuously valid (distinct addresses), write valid at 0x80, WR_MAX_WAIT=8 → the write is granted exactly on the 9th arbitration cycle. wait_cnt then returns to 0.
- wr_valid_i at 0x100 and rd_valid_i at 0x100 simultaneously → write issues first (mem_store_o=1), the read issues on the next grant.
- mem_ready_i=0 for 5 cycles with a command held → mem_* stable and all *_ready_o=0. mem_ready_i=1 → next pending request is granted in that same cycle.
- reset pulsed while mem_valid_o=1 and mem_ready_i=0 → next cycle mem_valid_o=0, all outputs zero, and wait_cnt=0.
- BYPASS_ENABLE=0 with by_valid_i=1 → by_ready_o never asserts and rd/wr arbitration is unaffected.
